// File: rtl/grf.sv
// 32 x 32-bit general register file: two combinational read ports, one synchronous write port.
// Also produces a registered commit trace (wb_*) and a running count of committed writes.
module grf #(
  parameter bit BYPASS   = 1'b1,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [31:0] PC,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc,
  output logic [31:0] wr_count
);

  logic [31:0] regs [32];
  logic        commit;

  // $0 is hardwired to zero, so writes to it never count as commits.
  assign commit = WE && (A3 != 5'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      wb_valid <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= 32'd0;
      wb_pc    <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      wb_valid <= commit;
      if (commit) begin
        regs[A3] <= WD;
        wb_addr  <= A3;
        wb_data  <= WD;
        wb_pc    <= PC;
        wr_count <= wr_count + 32'd1;
        if (TRACE_EN) $display("@%h: $%d <= %h", PC, A3, WD);
      end
    end
  end

  // Write-through lets an operand read see the value being written back this cycle.
  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a != 5'd0) begin
      if (BYPASS && WE && (A3 == a)) v = WD;
      else                           v = regs[a];
    end
    return v;
  endfunction

  always_comb begin
    RD1 = rd_port(A1);
    RD2 = rd_port(A2);
  end

endmodule

// File: tb/tb_grf.sv
// Randomized + directed scoreboard bench for grf, checking a BYPASS=1 and a BYPASS=0 instance.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
  logic [31:0] WD = '0, PC = '0;
  logic        WE = 1'b0;

  logic [31:0] rd1, rd2, wb_data, wb_pc, wr_count;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] rd1_n, rd2_n, wb_data_n, wb_pc_n, wr_count_n;
  logic        wb_valid_n;
  logic [4:0]  wb_addr_n;

  always #5 clk = ~clk;

  grf #(.BYPASS(1'b1), .TRACE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .WE(WE), .PC(PC),
    .RD1(rd1), .RD2(rd2), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_pc(wb_pc), .wr_count(wr_count)
  );

  grf #(.BYPASS(1'b0), .TRACE_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD(WD), .WE(WE), .PC(PC),
    .RD1(rd1_n), .RD2(rd2_n), .wb_valid(wb_valid_n), .wb_addr(wb_addr_n), .wb_data(wb_data_n),
    .wb_pc(wb_pc_n), .wr_count(wr_count_n)
  );

  typedef struct {
    logic [31:0] rd1, rd2, rd1n, rd2n;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd, wbp, cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Architectural reference state: what the register file should hold after each edge.
  logic [31:0] mregs [32];
  logic        mv;
  logic [4:0]  ma;
  logic [31:0] md, mp, mcnt;

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp, input logic we,
                                        input logic [4:0] a3, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (byp && we && a3 == a) return wd;
    return mregs[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per checked cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("rd1_bypass", rd1, e.rd1);
      cmp("rd2_bypass", rd2, e.rd2);
      cmp("rd1_nobypass", rd1_n, e.rd1n);
      cmp("rd2_nobypass", rd2_n, e.rd2n);
      cmp("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
      cmp("wb_valid_nb", {31'd0, wb_valid_n}, {31'd0, e.wbv});
      cmp("wb_addr", {27'd0, wb_addr}, {27'd0, e.wba});
      cmp("wb_data", wb_data, e.wbd);
      cmp("wb_pc", wb_pc, e.wbp);
      cmp("wr_count", wr_count, e.cnt);
      cmp("wr_count_nb", wr_count_n, e.cnt);
    end
  end

  task automatic step(input logic r, input logic we, input logic [4:0] a3, input logic [31:0] wd,
                      input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                      input bit chk, input bit preload);
    exp_t e;
    @(posedge clk);
    #1;
    if (preload) begin
      force dut.wr_count = 32'hFFFF_FFFF;
      force dut0.wr_count = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count;
      release dut0.wr_count;
      mcnt = 32'hFFFF_FFFF;
    end else begin
      #1;
    end
    reset = r; WE = we; A3 = a3; WD = wd; PC = pc; A1 = a1; A2 = a2;
    if (chk) begin
      e.rd1  = mread(a1, 1'b1, we, a3, wd);
      e.rd2  = mread(a2, 1'b1, we, a3, wd);
      e.rd1n = mread(a1, 1'b0, we, a3, wd);
      e.rd2n = mread(a2, 1'b0, we, a3, wd);
      e.wbv = mv; e.wba = ma; e.wbd = md; e.wbp = mp; e.cnt = mcnt;
      q.push_back(e);
    end
    // Effect of the coming edge.
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mv = 1'b0; ma = 5'd0; md = 32'd0; mp = 32'd0; mcnt = 32'd0;
    end else begin
      mv = we && (a3 != 0);
      if (mv) begin
        mregs[a3] = wd; ma = a3; md = wd; mp = pc; mcnt = mcnt + 32'd1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mv = 1'b0; ma = '0; md = '0; mp = '0; mcnt = '0;

    // Reset for two cycles; the first cycle precedes any known state.
    step(1, 0, 0, 0, 0, 5, 31, 0, 0);
    step(1, 0, 0, 0, 0, 5, 31, 1, 0);
    step(0, 0, 0, 0, 0, 5, 31, 1, 0);

    // Basic commit to $8, then read it back.
    step(0, 1, 8, 32'h1234_5678, 32'h0000_3000, 8, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8, 8, 1, 0);

    // Writes to $0 are discarded.
    step(0, 1, 0, 32'hFFFF_FFFF, 32'h0000_3004, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Bypass: $9 = 1, then overwrite with 7 while reading $9 on both ports.
    step(0, 1, 9, 32'd1, 32'h0000_3008, 0, 0, 1, 0);
    step(0, 1, 9, 32'd7, 32'h0000_300C, 9, 9, 1, 0);
    step(0, 0, 0, 0, 0, 9, 9, 1, 0);

    // Reset wins over a same-edge write.
    step(1, 1, 4, 32'd5, 32'h0000_3010, 4, 9, 1, 0);
    step(0, 0, 0, 0, 0, 4, 9, 1, 0);

    // Reset mid-stream after three writes.
    step(0, 1, 1, 32'hAAAA_0001, 32'h0000_4000, 1, 2, 1, 0);
    step(0, 1, 2, 32'hAAAA_0002, 32'h0000_4004, 1, 2, 1, 0);
    step(0, 1, 3, 32'hAAAA_0003, 32'h0000_4008, 2, 3, 1, 0);
    step(1, 0, 0, 0, 0, 1, 3, 1, 0);
    step(0, 0, 0, 0, 0, 1, 3, 1, 0);

    // Counter wrap: preload all-ones, one more commit wraps to zero and still writes.
    step(0, 1, 17, 32'hCAFE_F00D, 32'h0000_5000, 17, 0, 1, 1);
    step(0, 0, 0, 0, 0, 17, 17, 1, 0);

    // Randomized traffic with frequent $0 targets, port aliasing and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a3, a1, a2;
      logic r, we;
      a3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom);
      we = 1'($urandom);
      r  = ($urandom_range(0, 49) == 0);
      step(r, we, a3, $urandom, $urandom, a1, a2, 1, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    cmp("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
